// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if: maze map read port; the controller drives req/addr, the map answers ack/wall.
//   req  : read request, held until ack
//   addr : {cell_y, cell_x} of the queried cell, stable while req=1
//   ack  : read acknowledge
//   wall : queried cell is a wall, valid with ack
interface player_motion_ctrl_if #(parameter int AW = 8) ();
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic          wall;
  modport master (output req, addr, input ack, wall);
  modport slave (input req, addr, output ack, wall);
endinterface

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame heading update and collision-checked player movement.
//   clkin, resetn          : system clock, asynchronous active-low reset
//   frame_clk_i            : divided frame clock (level), rising edge triggers one update
//   key_{fwd,back,left,right}_i : movement keys, active high
//   map                    : map read port (master side)
//   pos_x_o, pos_y_o, dir_o: committed position (fixed point) and heading
//   update_done_o          : one-cycle pulse per completed update
//   overrun_o              : sticky, a frame edge arrived while one was pending
module player_motion_ctrl #(
  parameter int CELL_BITS = 4,
  parameter int FRAC_BITS = 8,
  parameter int STEP      = 32,
  parameter int START_X   = 'h180,
  parameter int START_Y   = 'h180,
  parameter int START_DIR = 0
) (
  input  logic                           clkin,
  input  logic                           resetn,
  input  logic                           frame_clk_i,
  input  logic                           key_fwd_i,
  input  logic                           key_back_i,
  input  logic                           key_left_i,
  input  logic                           key_right_i,
  player_motion_ctrl_if.master           map,
  output logic [CELL_BITS+FRAC_BITS-1:0] pos_x_o,
  output logic [CELL_BITS+FRAC_BITS-1:0] pos_y_o,
  output logic [2:0]                     dir_o,
  output logic                           update_done_o,
  output logic                           overrun_o
);
  localparam int W = CELL_BITS + FRAC_BITS;
  localparam logic signed [W:0] S = (W+1)'(STEP);
  localparam logic signed [W:0] D = (W+1)'(STEP * 181 / 256);
  typedef enum logic [2:0] {IDLE, ROTATE, REQ_X, REQ_Y, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] s1_q, s2_q;
  logic f3_q, fedge;
  logic pending_q, pending_d, overrun_q, overrun_d;
  logic [3:0] keys_q, keys_d;
  logic [W-1:0] px_q, px_d, py_q, py_d;
  logic [2:0] dir_q, dir_d, ndir;
  logic signed [W:0] cx_q, cx_d, cy_q, cy_d, sx, sy, dx, dy;
  logic mvx_q, mvx_d, mvy_q, mvy_d, need_x, need_y;
  // keys_q = {fwd, back, left, right}, same order as the synchroniser's low bits
  assign fedge = s2_q[4] & ~f3_q;
  assign ndir = dir_q + 3'(keys_q[0] & ~keys_q[1]) - 3'(keys_q[1] & ~keys_q[0]);
  assign sx = (ndir == 3'd0) ? S : (ndir == 3'd1 || ndir == 3'd7) ? D :
              (ndir == 3'd2 || ndir == 3'd6) ? '0 : (ndir == 3'd4) ? -S : -D;
  assign sy = (ndir == 3'd2) ? S : (ndir == 3'd1 || ndir == 3'd3) ? D :
              (ndir == 3'd0 || ndir == 3'd4) ? '0 : (ndir == 3'd6) ? -S : -D;
  assign dx = keys_q[2] ? -sx : sx;
  assign dy = keys_q[2] ? -sy : sy;
  // the extra top bit of a candidate is set both for negative and for past-the-map values
  assign need_x = mvx_q & ~cx_q[W];
  assign need_y = mvy_q & ~cy_q[W];
  assign pos_x_o = px_q;
  assign pos_y_o = py_q;
  assign dir_o = dir_q;
  assign overrun_o = overrun_q;
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      f3_q <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      keys_q <= '0;
      px_q <= W'(START_X);
      py_q <= W'(START_Y);
      dir_q <= 3'(START_DIR);
      cx_q <= '0;
      cy_q <= '0;
      mvx_q <= 1'b0;
      mvy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= {frame_clk_i, key_fwd_i, key_back_i, key_left_i, key_right_i};
      s2_q <= s1_q;
      f3_q <= s2_q[4];
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      keys_q <= keys_d;
      px_q <= px_d;
      py_q <= py_d;
      dir_q <= dir_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      mvx_q <= mvx_d;
      mvy_q <= mvy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q | fedge;
    overrun_d = overrun_q | (fedge & pending_q);
    keys_d = keys_q;
    px_d = px_q;
    py_d = py_q;
    dir_d = dir_q;
    cx_d = cx_q;
    cy_d = cy_q;
    mvx_d = mvx_q;
    mvy_d = mvy_q;
    map.req = 1'b0;
    map.addr = '0;
    update_done_o = 1'b0;
    case (state_q)
      IDLE: if (pending_q) begin
        pending_d = fedge;
        keys_d = s2_q[3:0];
        state_d = ROTATE;
      end
      ROTATE: begin
        dir_d = ndir;
        cx_d = $signed({1'b0, px_q}) + dx;
        cy_d = $signed({1'b0, py_q}) + dy;
        mvx_d = dx != '0;
        mvy_d = dy != '0;
        state_d = (keys_q[3] ^ keys_q[2]) ? REQ_X : DONE;
      end
      REQ_X: begin
        map.req = need_x;
        map.addr = need_x ? {py_q[W-1 -: CELL_BITS], cx_q[W-1 -: CELL_BITS]} : '0;
        state_d = (!need_x || map.ack) ? REQ_Y : REQ_X;
        px_d = (need_x && map.ack && !map.wall) ? cx_q[W-1:0] : px_q;
      end
      REQ_Y: begin
        // x is already committed here, so a blocked x still lets the player slide along y
        map.req = need_y;
        map.addr = need_y ? {cy_q[W-1 -: CELL_BITS], px_q[W-1 -: CELL_BITS]} : '0;
        state_d = (!need_y || map.ack) ? DONE : REQ_Y;
        py_d = (need_y && map.ack && !map.wall) ? cy_q[W-1:0] : py_q;
      end
      DONE: begin
        update_done_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
